// File: rtl/vector_alu_pkg.sv
// -----------------------------------------------------------------------------
// vector_alu_pkg
// Shared opcode encoding and sizing helper for the vector ALU pipeline.
//   valu_op_e  : 3-bit per-lane opcode (110/111 are illegal and yield zero)
//   LANES_OF   : number of lanes for a given vector width and lane width
// -----------------------------------------------------------------------------
package vector_alu_pkg;

  typedef enum logic [2:0] {
    VOP_ADD  = 3'b000,
    VOP_SUB  = 3'b001,
    VOP_XOR  = 3'b010,
    VOP_ROR  = 3'b011,
    VOP_ROL  = 3'b100,
    VOP_PASS = 3'b101
  } valu_op_e;

  function automatic int LANES_OF(input int n, input int lane_w);
    return n / lane_w;
  endfunction

endpackage

// File: rtl/vector_alu_lane.sv
// -----------------------------------------------------------------------------
// vector_alu_lane
// Combinational single-lane operation with carry/borrow flag.
// Lanes are fully independent: no carry enters or leaves a lane.
// Ports:
//   i_a     in  LANE_W  operand A lane
//   i_b     in  LANE_W  operand B lane (rotates use the low log2(LANE_W) bits)
//   i_op    in  3       opcode (valu_op_e encoding)
//   o_res   out LANE_W  lane result
//   o_carry out 1       ADD carry-out / SUB borrow (A < B unsigned); 0 otherwise
// Configuration:
//   VALU_SATURATE_EN  when defined, ADD clamps to all-ones and SUB clamps to
//                     zero; o_carry still reports the unclamped carry/borrow.
// -----------------------------------------------------------------------------
module vector_alu_lane
  import vector_alu_pkg::*;
#(
  parameter int LANE_W = 8
) (
  input  logic [LANE_W-1:0] i_a,
  input  logic [LANE_W-1:0] i_b,
  input  logic [2:0]        i_op,
  output logic [LANE_W-1:0] o_res,
  output logic              o_carry
);

  localparam int SH_W = (LANE_W > 1) ? $clog2(LANE_W) : 1;

  logic [LANE_W:0]     w_sum;
  logic [LANE_W:0]     w_dif;
  logic [SH_W-1:0]     w_amt;
  logic [2*LANE_W-1:0] w_dbl;
  logic [2*LANE_W-1:0] w_ror_full;
  logic [2*LANE_W-1:0] w_rol_full;

`ifdef VALU_SATURATE_EN
  function automatic logic [LANE_W-1:0] sat_add(input logic [LANE_W:0] sum);
    return sum[LANE_W] ? {LANE_W{1'b1}} : sum[LANE_W-1:0];
  endfunction

  function automatic logic [LANE_W-1:0] sat_sub(input logic [LANE_W:0] dif);
    return dif[LANE_W] ? {LANE_W{1'b0}} : dif[LANE_W-1:0];
  endfunction
`endif

  // One extra bit captures carry-out; for the difference it is the borrow.
  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign w_dif = {1'b0, i_a} - {1'b0, i_b};

  // Rotates via a doubled copy of the lane so amount 0 needs no special case.
  assign w_amt      = i_b[SH_W-1:0];
  assign w_dbl      = {i_a, i_a};
  assign w_ror_full = w_dbl >> w_amt;
  assign w_rol_full = w_dbl << w_amt;

  always_comb begin
    o_res   = '0;
    o_carry = 1'b0;
    case (i_op)
      VOP_ADD: begin
`ifdef VALU_SATURATE_EN
        o_res = sat_add(w_sum);
`else
        o_res = w_sum[LANE_W-1:0];
`endif
        o_carry = w_sum[LANE_W];
      end
      VOP_SUB: begin
`ifdef VALU_SATURATE_EN
        o_res = sat_sub(w_dif);
`else
        o_res = w_dif[LANE_W-1:0];
`endif
        o_carry = w_dif[LANE_W];
      end
      VOP_XOR:  o_res = i_a ^ i_b;
      VOP_ROR:  o_res = w_ror_full[LANE_W-1:0];
      VOP_ROL:  o_res = w_rol_full[2*LANE_W-1:LANE_W];
      VOP_PASS: o_res = i_a;
      default: begin
        o_res   = '0;
        o_carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/vector_alu_pipe.sv
// -----------------------------------------------------------------------------
// vector_alu_pipe
// Two-stage valid/ready vector ALU. S1 registers operands, opcode and tag;
// S2 registers the per-lane result, carry flags and tag. Full throughput
// under backpressure: S1 may refill in the same cycle S2 hands off.
// Ports:
//   clk         in   1       clock, rising edge
//   rst_n       in   1       asynchronous active-low reset
//   in_valid    in   1       operand bundle valid
//   in_ready    out  1       S1 can accept this cycle
//   regData1    in   N       operand A
//   regData2    in   N       operand B / per-lane rotate amount
//   aluControl  in   3       opcode
//   in_tag      in   TAG_W   destination tag
//   out_valid   out  1       result valid
//   out_ready   in   1       downstream accepts result
//   ALUV_res    out  N       result vector
//   out_tag     out  TAG_W   tag of ALUV_res
//   out_carry   out  LANES   per-lane carry (ADD) / borrow (SUB)
// Configuration:
//   VALU_SATURATE_EN  selects saturating ADD/SUB inside vector_alu_lane.
// -----------------------------------------------------------------------------
module vector_alu_pipe
  import vector_alu_pkg::*;
#(
  parameter int N      = 64,
  parameter int LANE_W = 8,
  parameter int TAG_W  = 5,
  localparam int LANES = LANES_OF(N, LANE_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     regData1,
  input  logic [N-1:0]     regData2,
  input  logic [2:0]       aluControl,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     ALUV_res,
  output logic [TAG_W-1:0] out_tag,
  output logic [LANES-1:0] out_carry
);

  logic             r_vld_p1;
  logic [N-1:0]     r_a_p1;
  logic [N-1:0]     r_b_p1;
  logic [2:0]       r_op_p1;
  logic [TAG_W-1:0] r_tag_p1;

  logic             r_vld_p2;
  logic [N-1:0]     r_res_p2;
  logic [TAG_W-1:0] r_tag_p2;
  logic [LANES-1:0] r_carry_p2;

  logic             w_s2_adv;
  logic             w_s1_load;
  logic             w_s2_load;
  logic [N-1:0]     w_res;
  logic [LANES-1:0] w_carry;

  // S2 can take a new entry when empty or when its current one leaves now;
  // out_ready -> in_ready is the only combinational path through the block.
  assign w_s2_adv  = !r_vld_p2 || out_ready;
  assign in_ready  = !r_vld_p1 || w_s2_adv;
  assign w_s1_load = in_valid && in_ready;
  assign w_s2_load = r_vld_p1 && w_s2_adv;

  // ---- Stage 1: operand capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
    end else if (in_ready) begin
      r_vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_s1_load) begin
      r_a_p1   <= regData1;
      r_b_p1   <= regData2;
      r_op_p1  <= aluControl;
      r_tag_p1 <= in_tag;
    end
  end

  // ---- Lane array (combinational between S1 and S2) ----
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    vector_alu_lane #(
      .LANE_W(LANE_W)
    ) u_lane (
      .i_a    (r_a_p1[l*LANE_W +: LANE_W]),
      .i_b    (r_b_p1[l*LANE_W +: LANE_W]),
      .i_op   (r_op_p1),
      .o_res  (w_res[l*LANE_W +: LANE_W]),
      .o_carry(w_carry[l])
    );
  end

  // ---- Stage 2: result register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2   <= 1'b0;
      r_res_p2   <= '0;
      r_tag_p2   <= '0;
      r_carry_p2 <= '0;
    end else begin
      if (w_s2_adv) begin
        r_vld_p2 <= r_vld_p1;
      end
      if (w_s2_load) begin
        r_res_p2   <= w_res;
        r_tag_p2   <= r_tag_p1;
        r_carry_p2 <= w_carry;
      end
    end
  end

  assign out_valid = r_vld_p2;
  assign ALUV_res  = r_res_p2;
  assign out_tag   = r_tag_p2;
  assign out_carry = r_carry_p2;

endmodule

// File: tb/tb_vector_alu_pipe.sv
module tb_vector_alu_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] regData1;
  logic [63:0] regData2;
  logic [2:0]  aluControl;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] ALUV_res;
  logic [4:0]  out_tag;
  logic [7:0]  out_carry;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  tag;
    logic [7:0]  carry;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_out    = 0;
  bit   saw_stall = 1'b0;

  vector_alu_pipe #(.N(64), .LANE_W(8), .TAG_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .regData1  (regData1),
    .regData2  (regData2),
    .aluControl(aluControl),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUV_res  (ALUV_res),
    .out_tag   (out_tag),
    .out_carry (out_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next rising edge whenever valid and
  // ready are both high mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && !in_ready) saw_stall = 1'b1;
      if (rst_n && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual_tag=%h required=none", out_tag);
        end else begin
          e = sb_q.pop_front();
          check("res",   ALUV_res,         e.res);
          check("tag",   {59'd0, out_tag},  {59'd0, e.tag});
          check("carry", {56'd0, out_carry}, {56'd0, e.carry});
          n_out++;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after acceptance with in_valid low.
  task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [4:0] tag, input logic [63:0] er, input logic [7:0] ec);
    bit ok;
    exp_t e;
    ok = 1'b0;
    in_valid   = 1'b1;
    aluControl = op;
    regData1   = a;
    regData2   = b;
    in_tag     = tag;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      e.res = er; e.tag = tag; e.carry = ec;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
    end else begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=in_ready_low required=accept tag=%h", tag);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    exp_t e;
    bit stale;

    // Test 1: reset with in_valid held high
    rst_n      = 1'b0;
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    aluControl = 3'b101;
    regData1   = 64'h1122334455667788;
    regData2   = 64'h0;
    in_tag     = 5'h03;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_res",       ALUV_res,           64'd0);
    check("rst_tag",       {59'd0, out_tag},   64'd0);
    check("rst_carry",     {56'd0, out_carry}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    e.res = 64'h1122334455667788; e.tag = 5'h03; e.carry = 8'h00;
    sb_q.push_back(e);
    @(posedge clk);   // acceptance edge: op enters S1
    #1;
    in_valid = 1'b0;
    check("lat_after_accept", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    check("lat_two_cycles", {63'd0, out_valid}, 64'd1);
    @(posedge clk);
    #1;

    // Test 2: ADD carry out of lane 0 only; lane 7 sums without carry
`ifdef VALU_SATURATE_EN
    send(3'b000, 64'h7F000000000000FF, 64'h0100000000000001, 5'h01, 64'h80000000000000FF, 8'h01);
`else
    send(3'b000, 64'h7F000000000000FF, 64'h0100000000000001, 5'h01, 64'h8000000000000000, 8'h01);
`endif
    // Test 3: SUB with borrow in lane 0, ROR, ROL
`ifdef VALU_SATURATE_EN
    send(3'b001, 64'h0000000000001005, 64'h0000000000000107, 5'h02, 64'h0000000000000F00, 8'h01);
    send(3'b001, 64'h0000000000000000, 64'h0101010101010101, 5'h04, 64'h0000000000000000, 8'hFF);
`else
    send(3'b001, 64'h0000000000001005, 64'h0000000000000107, 5'h02, 64'h0000000000000FFE, 8'h01);
    send(3'b001, 64'h0000000000000000, 64'h0101010101010101, 5'h04, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
`endif
    send(3'b011, 64'h0000000000AB0F81, 64'h0000000000080401, 5'h05, 64'h0000000000ABF0C0, 8'h00);
    send(3'b100, 64'h0000000000010F81, 64'h0000000000070401, 5'h06, 64'h000000000080F003, 8'h00);
    send(3'b010, 64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 5'h07, 64'h0FF00FF00FF00FF0, 8'h00);
    send(3'b101, 64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF, 5'h08, 64'h0123456789ABCDEF, 8'h00);
    // Test 5: illegal opcodes
    send(3'b111, 64'hDEADBEEFCAFEF00D, 64'h0123456789ABCDEF, 5'h1A, 64'h0, 8'h00);
    send(3'b110, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'h1B, 64'h0, 8'h00);
    repeat (6) @(posedge clk);
    #1;
    check("directed_drained", sb_q.size(), 64'd0);

    // Test 4: 8 back-to-back ops with out_ready low for four cycles
    base      = n_out;
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(3'b101, {8{8'(i + 8'h10)}}, 64'h0, 5'(5'h10 + i), {8{8'(i + 8'h10)}}, 8'h00);
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;
    check("stream_count",   n_out - base, 64'd8);
    check("stream_stalled", {63'd0, saw_stall}, 64'd1);
    check("stream_drained", sb_q.size(), 64'd0);

    // Test 6: async reset with two ops in flight
    out_ready = 1'b0;
    send(3'b101, 64'hAAAAAAAAAAAAAAAA, 64'h0, 5'h0A, 64'hAAAAAAAAAAAAAAAA, 8'h00);
    send(3'b101, 64'h5555555555555555, 64'h0, 5'h0B, 64'h5555555555555555, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_in_ready",  {63'd0, in_ready},  64'd1);
    check("arst_res",       ALUV_res,           64'd0);
    sb_q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("no_stale_after_reset", {63'd0, stale}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
